// File: rtl/geared_pkg.sv
// Shared helpers for the geared request splitter / response collector pair.
// Width functions keep lane indices and credit counters sized consistently on both sides.
package geared_pkg;

    // Width of an index into n entries; never zero so a single-entry case still has a bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold values 0..max_out inclusive.
    function automatic int unsigned cred_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/geared_lane_fifo.sv
// Single-clock FIFO with occupancy count; push while full is accepted only when a pop
// frees a slot in the same cycle. Pointers wrap modulo Depth, so any depth works.
module geared_lane_fifo
    import geared_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter type         T     = logic
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  T                             wdata_i,
    input  logic                         pop_i,
    output T                             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [cred_width(Depth)-1:0] usage_o
);

    localparam int unsigned PtrW   = idx_width(Depth);
    localparam int unsigned UsageW = cred_width(Depth);

    typedef logic [PtrW-1:0] ptr_t;

    T                  mem_q [Depth];
    ptr_t              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [UsageW-1:0] usage_q, usage_d;
    logic              push_ok, pop_ok;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign full_o  = (usage_q == UsageW'(Depth));
    assign empty_o = (usage_q == '0);
    assign usage_o = usage_q;
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        wptr_d  = push_ok ? next_ptr(wptr_q) : wptr_q;
        rptr_d  = pop_ok ? next_ptr(rptr_q) : rptr_q;
        usage_d = usage_q;
        if (push_ok && !pop_ok) begin
            usage_d = usage_q + UsageW'(1);
        end else if (!push_ok && pop_ok) begin
            usage_d = usage_q - UsageW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            usage_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            usage_q <= usage_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/geared_rsp_collector.sv
// Collects per-lane read responses of one geared requester and returns them in issue order.
// Per-lane credits bound lane buffer occupancy, so responses are never dropped.
module geared_rsp_collector
    import geared_pkg::*;
#(
    parameter int unsigned  NumLanes       = 2,
    parameter int unsigned  DataWidth      = 32,
    parameter int unsigned  MaxOutstanding = 4,
    localparam int unsigned OrderDepth     = NumLanes * MaxOutstanding,
    localparam int unsigned LaneIdxW       = idx_width(NumLanes)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          issue_valid_i,
    input  logic [LaneIdxW-1:0]           issue_lane_i,
    output logic                          issue_ready_o,
    input  logic [NumLanes-1:0]           lane_rvalid_i,
    input  logic [NumLanes*DataWidth-1:0] lane_rdata_i,
    output logic                          rvalid_o,
    output logic [DataWidth-1:0]          rdata_o,
    input  logic                          ready_i,
    output logic                          error_o
);

    localparam int unsigned CntW = cred_width(MaxOutstanding);
    localparam int unsigned OrdW = cred_width(OrderDepth);

    typedef logic [DataWidth-1:0] data_t;
    typedef logic [LaneIdxW-1:0]  lane_idx_t;

    logic                en_q;
    logic                error_q, error_d;
    logic [CntW-1:0]     cnt_q [NumLanes];
    logic [CntW-1:0]     cnt_d [NumLanes];
    logic                order_full, order_empty;
    lane_idx_t           head;
    logic [OrdW-1:0]     unused_order_usage;
    logic [NumLanes-1:0] lane_push, lane_pop, lane_empty, unused_lane_full;
    logic [CntW-1:0]     lane_usage [NumLanes];
    data_t               lane_head [NumLanes];
    logic                lane_ok, issue_fire, pop, spurious;

    // en_q holds issue_ready_o low during reset and releases it one clock later.
    assign lane_ok       = 32'(issue_lane_i) < NumLanes;
    assign issue_ready_o = en_q && !order_full && lane_ok
                           && (cnt_q[issue_lane_i] < CntW'(MaxOutstanding));
    assign issue_fire    = issue_valid_i && issue_ready_o;
    assign rvalid_o      = !order_empty && !lane_empty[head];
    assign pop           = rvalid_o && ready_i;
    assign rdata_o       = rvalid_o ? lane_head[head] : '0;
    assign error_o       = error_q;

    // A response is only legal while the lane has more issued requests than buffered data.
    always_comb begin
        spurious = 1'b0;
        for (int l = 0; l < NumLanes; l++) begin
            cnt_d[l]     = cnt_q[l];
            lane_push[l] = lane_rvalid_i[l] && (cnt_q[l] > lane_usage[l]);
            lane_pop[l]  = pop && (head == lane_idx_t'(l));
            spurious     = spurious | (lane_rvalid_i[l] & ~lane_push[l]);
            if (issue_fire && (issue_lane_i == lane_idx_t'(l))) begin
                cnt_d[l] = cnt_d[l] + CntW'(1);
            end
            if (lane_pop[l]) begin
                cnt_d[l] = cnt_d[l] - CntW'(1);
            end
        end
        error_d = error_q | spurious;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q    <= 1'b0;
            error_q <= 1'b0;
            for (int l = 0; l < NumLanes; l++) begin
                cnt_q[l] <= '0;
            end
        end else begin
            en_q    <= 1'b1;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    geared_lane_fifo #(
        .Depth (OrderDepth),
        .T     (lane_idx_t)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (issue_fire),
        .wdata_i (issue_lane_i),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (order_full),
        .empty_o (order_empty),
        .usage_o (unused_order_usage)
    );

    for (genvar g = 0; g < NumLanes; g++) begin : gen_lane
        geared_lane_fifo #(
            .Depth (MaxOutstanding),
            .T     (data_t)
        ) u_lane_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (lane_push[g]),
            .wdata_i (lane_rdata_i[g*DataWidth +: DataWidth]),
            .pop_i   (lane_pop[g]),
            .rdata_o (lane_head[g]),
            .full_o  (unused_lane_full[g]),
            .empty_o (lane_empty[g]),
            .usage_o (lane_usage[g])
        );
    end

endmodule
